sys_ctrl_rx: RTL and testbench

//  Command decoder between UART_RX and the register file (RF) / ALU. Parses byte frames from

---
 rtl/sys_ctrl_pkg.sv | 23 ++
 rtl/sys_ctrl_rx_timeout.sv | 28 ++
 rtl/sys_ctrl_rx.sv | 139 +++++++++++++
 tb/tb_sys_ctrl_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: command codes, FSM states, operand addresses.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    OP_A,
    OP_B,
    ALU_FUN_S,
    ALU_WAIT
  } rx_state_t;

endpackage

// File: rtl/sys_ctrl_rx_timeout.sv
// Mid-frame inactivity counter; expired flags the cycle the limit is reached with no byte.
module sys_ctrl_rx_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic byte_seen,
  input  logic active,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (byte_seen || !active) begin
      cnt <= '0;
    end else if (cnt != CW'(TIMEOUT_CYCLES - 1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = active && !byte_seen && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sys_ctrl_rx.sv
// Command decoder from UART_RX bytes to RF write/read strobes and ALU start controls.
// Optional mid-frame timeout abort enabled by defining SYS_CTRL_RX_TIMEOUT_EN.
module sys_ctrl_rx
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDRESS_WIDTH  = 4,
  parameter int unsigned FUN_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic                     OUT_VALID,
  output logic [ADDRESS_WIDTH-1:0] Address,
  output logic                     WrEn,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic                     RdEn,
  output logic                     ALU_EN,
  output logic [FUN_WIDTH-1:0]     ALU_FUN,
  output logic                     CLK_EN,
  output logic                     CMD_ERR
);

  rx_state_t                state;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic                     timeout_hit;

`ifdef SYS_CTRL_RX_TIMEOUT_EN
  logic frame_active;

  assign frame_active = (state != IDLE) && (state != ALU_WAIT);

  sys_ctrl_rx_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .byte_seen (RX_D_VLD),
    .active    (frame_active),
    .expired   (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      wr_addr <= '0;
      Address <= '0;
      WrEn    <= 1'b0;
      WrData  <= '0;
      RdEn    <= 1'b0;
      ALU_EN  <= 1'b0;
      ALU_FUN <= '0;
      CLK_EN  <= 1'b0;
      CMD_ERR <= 1'b0;
    end else begin
      WrEn    <= 1'b0;
      RdEn    <= 1'b0;
      ALU_EN  <= 1'b0;
      CMD_ERR <= 1'b0;
      if (timeout_hit) begin
        state   <= IDLE;
        CMD_ERR <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (RX_D_VLD) begin
              case (RX_P_DATA)
                DATA_WIDTH'(CMD_RF_WR):   state <= WR_ADDR;
                DATA_WIDTH'(CMD_RF_RD):   state <= RD_ADDR;
                DATA_WIDTH'(CMD_ALU_OP):  state <= OP_A;
                DATA_WIDTH'(CMD_ALU_NOP): state <= ALU_FUN_S;
                default:                  CMD_ERR <= 1'b1;
              endcase
            end
          end
          WR_ADDR: begin
            if (RX_D_VLD) begin
              wr_addr <= RX_P_DATA[ADDRESS_WIDTH-1:0];
              state   <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (RX_D_VLD) begin
              WrEn    <= 1'b1;
              Address <= wr_addr;
              WrData  <= RX_P_DATA;
              state   <= IDLE;
            end
          end
          RD_ADDR: begin
            if (RX_D_VLD) begin
              RdEn    <= 1'b1;
              Address <= RX_P_DATA[ADDRESS_WIDTH-1:0];
              state   <= IDLE;
            end
          end
          OP_A: begin
            if (RX_D_VLD) begin
              WrEn    <= 1'b1;
              Address <= ADDRESS_WIDTH'(OPA_ADDR);
              WrData  <= RX_P_DATA;
              state   <= OP_B;
            end
          end
          OP_B: begin
            if (RX_D_VLD) begin
              WrEn    <= 1'b1;
              Address <= ADDRESS_WIDTH'(OPB_ADDR);
              WrData  <= RX_P_DATA;
              state   <= ALU_FUN_S;
            end
          end
          ALU_FUN_S: begin
            if (RX_D_VLD) begin
              ALU_EN  <= 1'b1;
              CLK_EN  <= 1'b1;
              ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
              state   <= ALU_WAIT;
            end
          end
          ALU_WAIT: begin
            // Bytes arriving here are dropped; only OUT_VALID ends the operation.
            if (OUT_VALID) begin
              CLK_EN <= 1'b0;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_ctrl_rx.sv
// Directed self-checking bench for sys_ctrl_rx (timeout case under SYS_CTRL_RX_TIMEOUT_EN).
module tb_sys_ctrl_rx;

  localparam int unsigned TO = 64;

  logic       clk;
  logic       reset;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       OUT_VALID;
  logic [3:0] Address;
  logic       WrEn;
  logic [7:0] WrData;
  logic       RdEn;
  logic       ALU_EN;
  logic [3:0] ALU_FUN;
  logic       CLK_EN;
  logic       CMD_ERR;

  int vectors;
  int miscompares;

  sys_ctrl_rx #(
    .DATA_WIDTH     (8),
    .ADDRESS_WIDTH  (4),
    .FUN_WIDTH      (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RX_P_DATA (RX_P_DATA),
    .RX_D_VLD  (RX_D_VLD),
    .OUT_VALID (OUT_VALID),
    .Address   (Address),
    .WrEn      (WrEn),
    .WrData    (WrData),
    .RdEn      (RdEn),
    .ALU_EN    (ALU_EN),
    .ALU_FUN   (ALU_FUN),
    .CLK_EN    (CLK_EN),
    .CMD_ERR   (CMD_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns on the falling edge right after the capturing rising edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge clk);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wr"},  {31'd0, WrEn},    32'd0);
    check({tag, "_rd"},  {31'd0, RdEn},    32'd0);
    check({tag, "_alu"}, {31'd0, ALU_EN},  32'd0);
    check({tag, "_err"}, {31'd0, CMD_ERR}, 32'd0);
  endtask

  initial begin
    int err_cnt;
    int wr_cnt;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    RX_P_DATA   = 8'h00;
    RX_D_VLD    = 1'b0;
    OUT_VALID   = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("rst");
    check("rst_addr",  {28'd0, Address}, 32'h0);
    check("rst_wdata", {24'd0, WrData},  32'h0);
    check("rst_fun",   {28'd0, ALU_FUN}, 32'h0);
    check("rst_clken", {31'd0, CLK_EN},  32'h0);
    reset = 1'b1;

    // 1: RF write
    send_byte(8'hAA);
    check_quiet("t1_cmd");
    send_byte(8'h05);
    check_quiet("t1_addr");
    send_byte(8'h3C);
    check("t1_wren",  {31'd0, WrEn},     32'h1);
    check("t1_addr",  {28'd0, Address},  32'h5);
    check("t1_wdata", {24'd0, WrData},   32'h3C);
    check("t1_rden",  {31'd0, RdEn},     32'h0);
    check("t1_aluen", {31'd0, ALU_EN},   32'h0);
    @(negedge clk);
    check("t1_wren_1cyc", {31'd0, WrEn}, 32'h0);

    // 2: RF read
    send_byte(8'hBB);
    check_quiet("t2_cmd");
    send_byte(8'h0E);
    check("t2_rden", {31'd0, RdEn},    32'h1);
    check("t2_addr", {28'd0, Address}, 32'hE);
    check("t2_wren", {31'd0, WrEn},    32'h0);
    @(negedge clk);
    check("t2_rden_1cyc", {31'd0, RdEn}, 32'h0);

    // 3: ALU with operands
    send_byte(8'hCC);
    check_quiet("t3_cmd");
    send_byte(8'h07);
    check("t3_a_wren",  {31'd0, WrEn},    32'h1);
    check("t3_a_addr",  {28'd0, Address}, 32'h0);
    check("t3_a_wdata", {24'd0, WrData},  32'h07);
    send_byte(8'h03);
    check("t3_b_wren",  {31'd0, WrEn},    32'h1);
    check("t3_b_addr",  {28'd0, Address}, 32'h1);
    check("t3_b_wdata", {24'd0, WrData},  32'h03);
    send_byte(8'h00);
    check("t3_aluen", {31'd0, ALU_EN},  32'h1);
    check("t3_fun",   {28'd0, ALU_FUN}, 32'h0);
    check("t3_clken", {31'd0, CLK_EN},  32'h1);
    check("t3_wren",  {31'd0, WrEn},    32'h0);
    repeat (5) @(negedge clk);
    check("t3_aluen_1cyc", {31'd0, ALU_EN}, 32'h0);
    check("t3_clken_hold", {31'd0, CLK_EN}, 32'h1);
    OUT_VALID = 1'b1;
    @(negedge clk);
    OUT_VALID = 1'b0;
    check("t3_clken_off", {31'd0, CLK_EN}, 32'h0);

    // 4: ALU only, byte during ALU_WAIT ignored
    send_byte(8'hDD);
    check_quiet("t4_cmd");
    send_byte(8'h02);
    check("t4_aluen", {31'd0, ALU_EN},  32'h1);
    check("t4_fun",   {28'd0, ALU_FUN}, 32'h2);
    send_byte(8'h11);
    check_quiet("t4_drop");
    check("t4_fun_hold",   {28'd0, ALU_FUN}, 32'h2);
    check("t4_clken_hold", {31'd0, CLK_EN},  32'h1);
    OUT_VALID = 1'b1;
    @(negedge clk);
    OUT_VALID = 1'b0;
    check("t4_clken_off", {31'd0, CLK_EN},  32'h0);
    check("t4_fun_after", {28'd0, ALU_FUN}, 32'h2);

    // Simultaneous byte and OUT_VALID in ALU_WAIT: byte dropped, back to IDLE
    send_byte(8'hDD);
    send_byte(8'h09);
    check("sim_fun", {28'd0, ALU_FUN}, 32'h9);
    @(negedge clk);
    RX_P_DATA = 8'hAA;
    RX_D_VLD  = 1'b1;
    OUT_VALID = 1'b1;
    @(negedge clk);
    RX_D_VLD  = 1'b0;
    OUT_VALID = 1'b0;
    check_quiet("sim_drop");
    check("sim_clken", {31'd0, CLK_EN}, 32'h0);
    send_byte(8'hBB);
    send_byte(8'h04);
    check("sim_rden", {31'd0, RdEn},    32'h1);
    check("sim_addr", {28'd0, Address}, 32'h4);
    check("sim_wren", {31'd0, WrEn},    32'h0);

    // 5: unknown command, then normal decode
    send_byte(8'h55);
    check("t5_err",  {31'd0, CMD_ERR}, 32'h1);
    check("t5_wren", {31'd0, WrEn},    32'h0);
    @(negedge clk);
    check("t5_err_1cyc", {31'd0, CMD_ERR}, 32'h0);
    send_byte(8'hAA);
    check("t5_cmd_err", {31'd0, CMD_ERR}, 32'h0);
    send_byte(8'h01);
    send_byte(8'hFF);
    check("t5_wren",  {31'd0, WrEn},    32'h1);
    check("t5_addr",  {28'd0, Address}, 32'h1);
    check("t5_wdata", {24'd0, WrData},  32'hFF);

    // Address truncation
    send_byte(8'hBB);
    send_byte(8'h3A);
    check("trunc_rden", {31'd0, RdEn},    32'h1);
    check("trunc_addr", {28'd0, Address}, 32'hA);
    check("trunc_err",  {31'd0, CMD_ERR}, 32'h0);

    // Command code as data is data
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'hBB);
    check("cdata_wren",  {31'd0, WrEn},    32'h1);
    check("cdata_addr",  {28'd0, Address}, 32'h2);
    check("cdata_wdata", {24'd0, WrData},  32'hBB);
    check("cdata_rden",  {31'd0, RdEn},    32'h0);
    send_byte(8'h66);
    check("cdata_idle_err", {31'd0, CMD_ERR}, 32'h1);

    // 6: reset mid-frame
    send_byte(8'hAA);
    send_byte(8'h03);
    #2 reset = 1'b0;
    #1;
    check_quiet("t6_rst");
    check("t6_rst_addr",  {28'd0, Address}, 32'h0);
    check("t6_rst_wdata", {24'd0, WrData},  32'h0);
    check("t6_rst_fun",   {28'd0, ALU_FUN}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    send_byte(8'hBB);
    check_quiet("t6_cmd");
    send_byte(8'h03);
    check("t6_rden", {31'd0, RdEn},    32'h1);
    check("t6_addr", {28'd0, Address}, 32'h3);
    check("t6_wren", {31'd0, WrEn},    32'h0);

`ifdef SYS_CTRL_RX_TIMEOUT_EN
    send_byte(8'hAA);
    send_byte(8'h03);
    err_cnt = 0;
    wr_cnt  = 0;
    for (int i = 0; i < int'(TO) + 8; i++) begin
      @(negedge clk);
      if (CMD_ERR) err_cnt++;
      if (WrEn)    wr_cnt++;
    end
    check("to_err_cnt", err_cnt, 32'd1);
    check("to_wr_cnt",  wr_cnt,  32'd0);
    send_byte(8'h07);
    check("to_back_idle", {31'd0, CMD_ERR}, 32'h1);
`else
    err_cnt = 0;
    wr_cnt  = 0;
    send_byte(8'hAA);
    send_byte(8'h03);
    for (int i = 0; i < int'(TO) + 8; i++) begin
      @(negedge clk);
      if (CMD_ERR) err_cnt++;
      if (WrEn)    wr_cnt++;
    end
    check("wait_err_cnt", err_cnt, 32'd0);
    check("wait_wr_cnt",  wr_cnt,  32'd0);
    send_byte(8'h07);
    check("wait_wren",  {31'd0, WrEn},    32'h1);
    check("wait_addr",  {28'd0, Address}, 32'h3);
    check("wait_wdata", {24'd0, WrData},  32'h07);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
